// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Round-robin arbiter for a shared 2:1 datapath mux, with a
//                one-entry valid/ready output register and burst capping.
//  Revision    : 1.0
// ============================================================================
module mux_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ack,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] c_one       = CW'(1);
    localparam logic [CW-1:0] c_burst_end = CW'(MAX_BURST - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_last_sel;
    logic             w_last_sel_nxt;
    logic [CW-1:0]    r_burst_cnt;
    logic [CW-1:0]    w_burst_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic w_req_sel;
    logic w_space;
    logic w_cap;

    assign w_req_sel = r_sel ? b_req : a_req;
    assign w_space   = ~r_out_valid | out_ready;
    // Gated by rst so a reset cycle never acknowledges a word it then discards.
    assign w_cap     = (r_state == S_GRANT) & w_req_sel & w_space & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_last_sel  <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_last_sel  <= w_last_sel_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_last_sel_nxt = r_last_sel;
        w_burst_nxt    = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (a_req && b_req) begin
                    w_sel_nxt   = ~r_last_sel;
                    w_state_nxt = S_GRANT;
                end else if (a_req || b_req) begin
                    w_sel_nxt   = b_req;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_req_sel || (w_cap && (r_burst_cnt == c_burst_end))) begin
                    w_state_nxt    = S_IDLE;
                    w_last_sel_nxt = r_sel;
                    w_burst_nxt    = '0;
                end else if (w_cap) begin
                    w_burst_nxt = r_burst_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    always_comb begin
        a_ack = w_cap & ~r_sel;
        b_ack = w_cap &  r_sel;
        busy  = (r_state == S_GRANT);
    end

    // Output register runs independently of the FSM; drain and refill may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_sel ? b_data : a_data;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arbiter
//  Description : Directed self-checking bench for mux_arbiter.
//  Revision    : 1.0
// ============================================================================
module tb_mux_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             a_ack;
    logic             b_req;
    logic [WIDTH-1:0] b_data;
    logic             b_ack;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;

    int n_cmp;
    int n_err;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_data    (a_data),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_data    (b_data),
        .b_ack     (b_ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        a_req     = 1'b0;
        b_req     = 1'b0;
        out_ready = 1'b1;
        to_next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            to_sample();
            n_cmp++;
            if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ack cycle %0d: a_ack=%b b_ack=%b required 0/0", c, a_ack, b_ack);
            end
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 16'h0000 || sel !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state cycle %0d: valid=%b data=%h sel=%b busy=%b required 0/0000/0/0",
                         c, out_valid, out_data, sel, busy);
            end
            to_next();
        end
        rst   = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        to_next();
    endtask

    task automatic test_a_only();
        logic [7:0] exp_ack;
        exp_ack = 8'hDE;
        do_reset();
        a_req  = 1'b1;
        a_data = 16'h1234;
        for (int c = 0; c < 8; c++) begin
            to_sample();
            n_cmp++;
            if (a_ack !== exp_ack[c] || b_ack !== 1'b0) begin
                n_err++;
                $display("FAIL a_only_ack cycle %0d: a_ack=%b b_ack=%b required %b/0", c, a_ack, b_ack, exp_ack[c]);
            end
            n_cmp++;
            if (busy !== exp_ack[c]) begin
                n_err++;
                $display("FAIL a_only_busy cycle %0d: busy=%b required %b", c, busy, exp_ack[c]);
            end
            if (c == 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
                    n_err++;
                    $display("FAIL a_only_latency: valid=%b data=%h required 1/1234", out_valid, out_data);
                end
            end
            to_next();
        end
        a_req = 1'b0;
        to_next();
    endtask

    task automatic test_round_robin();
        logic [14:0] exp_a;
        logic [14:0] exp_b;
        exp_a = 15'h781E;
        exp_b = 15'h03C0;
        do_reset();
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_data = 16'hA0A0;
        b_data = 16'hB0B0;
        for (int c = 0; c < 15; c++) begin
            to_sample();
            n_cmp++;
            if (a_ack !== exp_a[c] || b_ack !== exp_b[c]) begin
                n_err++;
                $display("FAIL rr_ack cycle %0d: a_ack=%b b_ack=%b required %b/%b", c, a_ack, b_ack, exp_a[c], exp_b[c]);
            end
            if (exp_a[c] || exp_b[c]) begin
                n_cmp++;
                if (sel !== exp_b[c]) begin
                    n_err++;
                    $display("FAIL rr_sel cycle %0d: sel=%b required %b", c, sel, exp_b[c]);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (out_data !== 16'hB0B0) begin
                    n_err++;
                    $display("FAIL rr_data: out_data=%h required b0b0", out_data);
                end
            end
            to_next();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        to_next();
    endtask

    task automatic test_backpressure();
        int acks;
        acks = 0;
        do_reset();
        out_ready = 1'b0;
        a_req     = 1'b1;
        a_data    = 16'hAAAA;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) a_data = 16'hAAAB;
            if (c == 6) out_ready = 1'b1;
            to_sample();
            if (c >= 1 && c <= 5 && a_ack === 1'b1) acks++;
            if (c >= 2 && c <= 6) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
                    n_err++;
                    $display("FAIL bp_hold cycle %0d: valid=%b data=%h required 1/aaaa", c, out_valid, out_data);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (a_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_resume_ack: a_ack=%b required 1", a_ack);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'hAAAB) begin
                    n_err++;
                    $display("FAIL bp_next_word: valid=%b data=%h required 1/aaab", out_valid, out_data);
                end
            end
            to_next();
        end
        n_cmp++;
        if (acks != 1) begin
            n_err++;
            $display("FAIL bp_ack_count: acks=%0d required 1", acks);
        end
        a_req = 1'b0;
        to_next();
    endtask

    task automatic test_drop();
        logic [5:0] exp_b;
        logic [5:0] exp_busy;
        exp_b    = 6'b000110;
        exp_busy = 6'b101110;
        do_reset();
        b_req  = 1'b1;
        b_data = 16'hBEEF;
        a_data = 16'hCAFE;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) a_req = 1'b1;
            if (c == 3) b_req = 1'b0;
            if (c == 4) b_req = 1'b1;
            to_sample();
            n_cmp++;
            if (b_ack !== exp_b[c] || a_ack !== (c == 5)) begin
                n_err++;
                $display("FAIL drop_ack cycle %0d: a_ack=%b b_ack=%b required %b/%b", c, a_ack, b_ack, (c == 5), exp_b[c]);
            end
            n_cmp++;
            if (busy !== exp_busy[c]) begin
                n_err++;
                $display("FAIL drop_busy cycle %0d: busy=%b required %b", c, busy, exp_busy[c]);
            end
            if (c == 5) begin
                n_cmp++;
                if (sel !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_regrant_sel: sel=%b required 0", sel);
                end
            end
            to_next();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        to_next();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        a_req     = 1'b1;
        a_data    = 16'h5A5A;
        b_data    = 16'h0B0B;
        to_next();
        to_next();
        rst       = 1'b1;
        b_req     = 1'b1;
        out_ready = 1'b1;
        to_sample();
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_setup: valid=%b busy=%b required 1/1", out_valid, busy);
        end
        n_cmp++;
        if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ack: a_ack=%b b_ack=%b required 0/0", a_ack, b_ack);
        end
        to_next();
        rst = 1'b0;
        to_sample();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rstmid_cleared: valid=%b busy=%b data=%h required 0/0/0000", out_valid, busy, out_data);
        end
        to_next();
        to_sample();
        n_cmp++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0 || sel !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_first_grant: a_ack=%b b_ack=%b sel=%b required 1/0/0", a_ack, b_ack, sel);
        end
        to_next();
        a_req = 1'b0;
        b_req = 1'b0;
        to_next();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        a_req     = 1'b1;
        b_req     = 1'b1;
        a_data    = 16'h1111;
        b_data    = 16'h2222;
        out_ready = 1'b1;
        test_reset();
        test_a_only();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
